// File: rtl/coffee_dispense_sequencer_if.sv
// rtl/coffee_dispense_sequencer_if.sv - order, lookup and valve signals of the dispense sequencer
interface coffee_dispense_sequencer_if;
  logic       start;
  logic [2:0] coffee_type_in;
  logic       cancel;
  logic [1:0] ingredient_time;
  logic [2:0] coffee_type;
  logic [2:0] ingredient_state;
  logic [4:0] valve;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, coffee_type_in, cancel, ingredient_time,
    input  coffee_type, ingredient_state, valve, busy, done, error
  );

  modport slave (
    input  start, coffee_type_in, cancel, ingredient_time,
    output coffee_type, ingredient_state, valve, busy, done, error
  );
endinterface

// File: rtl/coffee_dispense_sequencer.sv
// rtl/coffee_dispense_sequencer.sv - walks the five ingredients of a latched order and times each valve
module coffee_dispense_sequencer #(
  parameter int TICKS_PER_UNIT = 50000000,
  parameter int CNT_W          = 32
) (
  input logic clk,
  input logic reset,
  coffee_dispense_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DISPENSE, DONE} state_t;

  localparam logic [CNT_W-1:0] TPU = CNT_W'(TICKS_PER_UNIT);

  state_t           state, state_n;
  logic [2:0]       type_q, type_n;
  logic [2:0]       ing_q, ing_n;
  logic [4:0]       valve_q, valve_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             error_q, error_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      type_q  <= '0;
      ing_q   <= '0;
      valve_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      type_q  <= type_n;
      ing_q   <= ing_n;
      valve_q <= valve_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      error_q <= error_n;
      cnt_q   <= cnt_n;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_n = state;
    type_n  = type_q;
    ing_n   = ing_q;
    valve_n = valve_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    error_n = 1'b0;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        busy_n  = 1'b0;
        valve_n = '0;
        if (bus.start) begin
          if (!bus.coffee_type_in[2]) begin
            type_n  = bus.coffee_type_in;
            ing_n   = '0;
            busy_n  = 1'b1;
            state_n = LOAD;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.cancel) begin
          state_n = IDLE;
          valve_n = '0;
          busy_n  = 1'b0;
          ing_n   = '0;
          cnt_n   = '0;
        end else if (bus.ingredient_time != 2'd0) begin
          cnt_n   = CNT_W'(bus.ingredient_time) * TPU - CNT_W'(1);
          valve_n = 5'd1 << ing_q;
          state_n = DISPENSE;
        end else if (ing_q == 3'd4) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ing_n   = '0;
        end else begin
          ing_n = ing_q + 3'd1;
        end
      end
      DISPENSE: begin
        // Cancel wins over a counter that happens to expire on the same edge.
        if (bus.cancel) begin
          state_n = IDLE;
          valve_n = '0;
          busy_n  = 1'b0;
          ing_n   = '0;
          cnt_n   = '0;
        end else if (cnt_q == '0) begin
          valve_n = '0;
          if (ing_q == 3'd4) begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            ing_n   = '0;
          end else begin
            ing_n   = ing_q + 3'd1;
            state_n = LOAD;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        valve_n = '0;
        ing_n   = '0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        valve_n = '0;
        ing_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.coffee_type      = type_q;
  assign bus.ingredient_state = ing_q;
  assign bus.valve            = valve_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;

endmodule

// File: tb/tb_coffee_dispense_sequencer.sv
// tb/tb_coffee_dispense_sequencer.sv - bench for two sequencers (1 and 4 ticks per unit) against an order-timeline model
module tb_coffee_dispense_sequencer;

  typedef struct packed {
    logic [2:0] ct;
    logic [2:0] ing;
    logic [4:0] valve;
    logic       busy;
    logic       done;
    logic       error;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, cancel;
  logic [2:0] cti;
  int         checks = 0;
  int         failures = 0;
  logic       chk_en = 1'b0;

  exp_t tl [2][128];
  int   tl_len [2];
  int   tl_pos [2];
  exp_t cur [2];

  always #5 clk = ~clk;

  function automatic logic [1:0] lut(input logic [2:0] ct, input logic [2:0] i);
    logic [9:0] row;
    int         idx;
    case (ct)
      3'd0:    row = {2'd1, 2'd0, 2'd0, 2'd3, 2'd2};
      3'd1:    row = {2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
      3'd2:    row = {2'd1, 2'd0, 2'd2, 2'd1, 2'd2};
      3'd3:    row = {2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
      default: row = '0;
    endcase
    idx = 2 * int'(i);
    return (i <= 3'd4) ? row[idx +: 2] : 2'd0;
  endfunction

  coffee_dispense_sequencer_if if0 ();
  coffee_dispense_sequencer_if if1 ();

  assign if0.start           = start;
  assign if0.coffee_type_in  = cti;
  assign if0.cancel          = cancel;
  assign if0.ingredient_time = lut(if0.coffee_type, if0.ingredient_state);
  assign if1.start           = start;
  assign if1.coffee_type_in  = cti;
  assign if1.cancel          = cancel;
  assign if1.ingredient_time = lut(if1.coffee_type, if1.ingredient_state);

  coffee_dispense_sequencer #(.TICKS_PER_UNIT(1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  coffee_dispense_sequencer #(.TICKS_PER_UNIT(4), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  function automatic exp_t mk(input logic [2:0] ct, input logic [2:0] ing, input logic [4:0] v,
                              input logic b, input logic d, input logic e);
    exp_t r;
    r.ct = ct; r.ing = ing; r.valve = v; r.busy = b; r.done = d; r.error = e;
    return r;
  endfunction

  // An accepted order is expanded into its full per-cycle output timeline, then replayed.
  task automatic model_step(input int k);
    int t;
    int n;
    t = (k == 0) ? 1 : 4;
    if (reset) begin
      cur[k] = '0;
      tl_len[k] = 0;
      tl_pos[k] = 0;
    end else if (cur[k].busy && cancel) begin
      cur[k] = mk(cur[k].ct, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tl_len[k] = 0;
      tl_pos[k] = 0;
    end else if (tl_pos[k] < tl_len[k]) begin
      cur[k] = tl[k][tl_pos[k]];
      tl_pos[k]++;
    end else if (start && !cur[k].done && cti <= 3'd3) begin
      n = 0;
      for (int i = 0; i < 5; i++) begin
        tl[k][n] = mk(cti, 3'(i), 5'd0, 1'b1, 1'b0, 1'b0);
        n++;
        for (int j = 0; j < int'(lut(cti, 3'(i))) * t; j++) begin
          tl[k][n] = mk(cti, 3'(i), 5'(1 << i), 1'b1, 1'b0, 1'b0);
          n++;
        end
      end
      tl[k][n] = mk(cti, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      tl_len[k] = n + 1;
      cur[k] = tl[k][0];
      tl_pos[k] = 1;
    end else if (start && !cur[k].done) begin
      cur[k] = mk(cur[k].ct, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    end else begin
      cur[k] = mk(cur[k].ct, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    cur[0] = '0; cur[1] = '0;
    tl_len[0] = 0; tl_len[1] = 0; tl_pos[0] = 0; tl_pos[1] = 0;
  end

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t snap0();
    return {if0.coffee_type, if0.ingredient_state, if0.valve, if0.busy, if0.done, if0.error};
  endfunction
  function automatic exp_t snap1();
    return {if1.coffee_type, if1.ingredient_state, if1.valve, if1.busy, if1.done, if1.error};
  endfunction

  // Every cycle, both DUTs are held against the model on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("model_dut0", 64'(snap0()), 64'(cur[0]));
      chk("model_dut1", 64'(snap1()), 64'(cur[1]));
    end
  endtask

  task automatic run_order(input logic [2:0] ty, input int b0, input int b1, input int d0,
                           input logic [39:0] v0, input logic [39:0] v1);
    int busy0, busy1, done_at0, dones0, dones1;
    logic [39:0] vc0, vc1;
    busy0 = 0; busy1 = 0; done_at0 = 0; dones0 = 0; dones1 = 0; vc0 = '0; vc1 = '0;
    cti = ty;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start = 1'b0;
      if (if0.busy) busy0++;
      if (if1.busy) busy1++;
      if (if0.done) begin dones0++; if (done_at0 == 0) done_at0 = c; end
      if (if1.done) dones1++;
      for (int b = 0; b < 5; b++) begin
        if (if0.valve[b]) vc0[8*b +: 8] = vc0[8*b +: 8] + 8'd1;
        if (if1.valve[b]) vc1[8*b +: 8] = vc1[8*b +: 8] + 8'd1;
      end
    end
    chk("busy_cycles_t1", 64'(busy0), 64'(b0));
    chk("busy_cycles_t4", 64'(busy1), 64'(b1));
    chk("done_latency_t1", 64'(done_at0), 64'(d0));
    chk("done_count", 64'({dones0, dones1}), {32'd1, 32'd1});
    chk("valve_cycles_t1", 64'(vc0), 64'(v0));
    chk("valve_cycles_t4", 64'(vc1), 64'(v1));
  endtask

  initial begin
    int found, dones;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; cti = 3'd0;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_state", 64'({snap0(), snap1()}), 64'd0);
    reset = 1'b0;
    tick();

    run_order(3'd0, 11, 29, 12, {8'd1, 8'd0, 8'd0, 8'd3, 8'd2}, {8'd4, 8'd0, 8'd0, 8'd12, 8'd8});
    run_order(3'd3, 11, 29, 12, {8'd1, 8'd2, 8'd1, 8'd1, 8'd1}, {8'd4, 8'd8, 8'd4, 8'd4, 8'd4});
    run_order(3'd2, 11, 29, 12, {8'd1, 8'd0, 8'd2, 8'd1, 8'd2}, {8'd4, 8'd0, 8'd8, 8'd4, 8'd8});

    cti = 3'd1;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      start = 1'b0;
      if (if0.valve == 5'b00010) found = 1;
    end
    chk("cancel_reached_coffee", 64'(found), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_idle", 64'({if0.busy, if0.valve, if1.busy, if1.valve}), 64'd0);
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (if0.done || if1.done) dones++;
    end
    chk("cancel_no_done", 64'(dones), 64'd0);
    run_order(3'd0, 11, 29, 12, {8'd1, 8'd0, 8'd0, 8'd3, 8'd2}, {8'd4, 8'd0, 8'd0, 8'd12, 8'd8});

    cti = 3'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_type_error", 64'({snap0(), snap1()}), 64'({14'b1, 14'b1}));
    tick();
    chk("bad_type_error_clear", 64'({if0.error, if1.error}), 64'd0);

    cti = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    cti = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (if0.done) dones++;
    end
    chk("start_while_busy", 64'({dones, 29'd0, if0.coffee_type}), {32'd1, 32'd0});

    cti = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_zero", 64'({snap0(), snap1()}), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (if0.done || if1.done) dones++;
    end
    chk("mid_reset_no_done", 64'(dones), 64'd0);

    for (int c = 0; c < 4000; c++) begin
      reset  = ($urandom_range(0, 199) == 0);
      cancel = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 3) == 0);
      cti    = 3'($urandom_range(0, 7));
      tick();
    end
    reset = 1'b0; cancel = 1'b0; start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coffee_dispense_sequencer.md
Name: coffee_dispense_sequencer

Overview:
Consumer side of the per-coffee ingredient-time lookup. It latches a coffee order, walks ingredient indices 0..4 (water, coffee, milk, chocolate, sugar) and presents each {coffee_type, ingredient index} to the lookup. It reads back the 2-bit ingredient_time, opens the matching valve for ingredient_time × TICKS_PER_UNIT clock cycles, then pulses done. It sits between the order/button logic and the valve drivers of the coffee machine.

Parameters:
TICKS_PER_UNIT, 50000000, clock cycles per ingredient time unit (1 s at 50 MHz); must be ≥1.
CNT_W, 32, width of the internal tick counter; must hold 3*TICKS_PER_UNIT-1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  order request; sampled only in IDLE.
coffee_type_in  in  3  order type: 0 espresso, 1 with milk, 2 cappuccino, 3 mocaccino.
cancel  in  1  abort the current order.
ingredient_time  in  2  lookup result for the presented {coffee_type, ingredient_state}; combinational, valid the same cycle.
coffee_type  out  3  latched order type, driven to the lookup.
ingredient_state  out  3  current ingredient index 0..4, driven to the lookup.
valve  out  5  one-hot valve enables: bit0 water, bit1 coffee, bit2 milk, bit3 chocolate, bit4 sugar.
busy  out  1  high in LOAD and DISPENSE.
done  out  1  one-cycle pulse on normal completion.
error  out  1  one-cycle pulse when an order is rejected.

Behaviour:
- Reset (sync, active-high): state IDLE; coffee_type=0, ingredient_state=0, valve=0, busy=0, done=0, error=0, counter=0. Overrides every other input; mid-order reset closes all valves at the next edge, with no done pulse.
- States: IDLE, LOAD, DISPENSE, DONE. All outputs are registered.
- IDLE: if start=1 and coffee_type_in ≤ 3: latch coffee_type, ingredient_state←0, go to LOAD. If start=1 and coffee_type_in > 3: error=1 for the next cycle, stay in IDLE, coffee_type unchanged. start while not in IDLE is ignored.
- LOAD (1 cycle, busy=1, valve=0): sample ingredient_time.
  - If nonzero: counter ← ingredient_time*TICKS_PER_UNIT-1, valve ← one-hot(ingredient_state), go to DISPENSE.
  - If zero: the ingredient is skipped. If ingredient_state=4 go to DONE; else increment ingredient_state and stay in LOAD.
- DISPENSE (busy=1): valve held; counter decrements each cycle. On the edge where counter=0: valve←0. If ingredient_state=4 go to DONE; else ingredient_state+1 and go to LOAD.
  - Each valve is high exactly ingredient_time*TICKS_PER_UNIT consecutive cycles.
  - Only one valve bit is ever set.
- DONE (1 cycle): done=1, busy=0, valve=0, ingredient_state←0. Next state is IDLE. start is not accepted in DONE.
- cancel=1 in LOAD or DISPENSE: at the next edge go to IDLE, valve=0, busy=0, ingredient_state=0, no done. cancel in IDLE or DONE has no effect. reset has priority over cancel; cancel has priority over counter expiry.
- ingredient_state never exceeds 4. Counter arithmetic is unsigned CNT_W bits and never underflows.
- Total busy cycles per order = 5 LOAD cycles + Σ(ingredient_time_i)*TICKS_PER_UNIT.

Test Plan:
- TICKS_PER_UNIT=1, start with type 0 (espresso, times 2,3,0,0,1): valve sequence water×2, coffee×3, sugar×1; milk and chocolate skipped; busy high 11 cycles; done pulses on the 12th cycle after start is sampled.
- TICKS_PER_UNIT=1, type 3 (1,1,1,2,1): valve bits 0,1,2,3,3,4 across DISPENSE cycles; busy 11 cycles; exactly one done pulse.
- TICKS_PER_UNIT=4, type 2 (2,1,2,0,1): water valve 8 cycles, coffee 4, milk 8, chocolate never set, sugar 4; busy 29 cycles.
- Cancel during the coffee valve of type 1: valve=0 and busy=0 on the next cycle; no done; a new start for type 0 then completes normally.
- start with coffee_type_in=5 -> error pulse for 1 cycle, busy stays 0, valve stays 0. start asserted during busy -> ignored, current order unaffected.
- Reset asserted mid-DISPENSE -> next cycle all outputs 0 and FSM in IDLE; no done pulse afterwards.
